// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/decode/execute control FSM with timed memory req/ack handshake
// Optional feature macro: SEQ_SINGLE_STEP_EN (ADVANCE returns to IDLE, one instruction per start)
module cpu_sequencer #(
    parameter int OPCODE_WIDTH = 3,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic                    clock,
    input  logic                    n_reset,
    input  logic                    start,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    mem_ack,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic                    ir_load,
    output logic                    alu_en,
    output logic                    reg_we,
    output logic                    pc_en,
    output logic                    halted,
    output logic                    fault,
    output logic [2:0]              state
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_ALU   = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(7);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_MEM     = 3'd4,
        S_ADVANCE = 3'd5,
        S_HALT    = 3'd6,
        S_FAULT   = 3'd7
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [OPCODE_WIDTH-1:0] op_q, op_d;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    // Wait counter defaults to zero so every entry into FETCH/MEM starts a fresh count.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        op_d    = op_q;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        ir_load = 1'b0;
        alu_en  = 1'b0;
        reg_we  = 1'b0;
        pc_en   = 1'b0;
        halted  = 1'b0;
        fault   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH, S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (state_q == S_MEM) && (op_q == OP_STORE);
                // An ack on the limit cycle still completes the transfer.
                if (mem_ack) begin
                    if (state_q == S_FETCH) begin
                        ir_load = 1'b1;
                        state_d = S_DECODE;
                    end else begin
                        reg_we  = (op_q == OP_LOAD);
                        state_d = S_ADVANCE;
                    end
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_NOP, OP_ALU, OP_LOAD, OP_STORE: state_d = S_EXEC;
                    OP_HALT:                           state_d = S_HALT;
                    default:                           state_d = S_FAULT;
                endcase
            end
            S_EXEC: begin
                if (op_q == OP_ALU) begin
                    alu_en = 1'b1;
                    reg_we = 1'b1;
                end
                if (op_q == OP_LOAD || op_q == OP_STORE) state_d = S_MEM;
                else                                     state_d = S_ADVANCE;
            end
            S_ADVANCE: begin
                pc_en = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
                state_d = S_IDLE;
`else
                state_d = S_FETCH;
`endif
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: state_d = state_q;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;
    logic       clock = 1'b0;
    logic       n_reset;
    logic       start;
    logic [2:0] opcode;
    logic       mem_ack;
    logic       mem_req, mem_we, ir_load, alu_en, reg_we, pc_en, halted, fault;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    cpu_sequencer dut (
        .clock   (clock),
        .n_reset (n_reset),
        .start   (start),
        .opcode  (opcode),
        .mem_ack (mem_ack),
        .mem_req (mem_req),
        .mem_we  (mem_we),
        .ir_load (ir_load),
        .alu_en  (alu_en),
        .reg_we  (reg_we),
        .pc_en   (pc_en),
        .halted  (halted),
        .fault   (fault),
        .state   (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Called at edge+2; asserts reset between edges, then releases after one edge.
    task automatic do_reset(input string tag);
        n_reset = 1'b0;
        start   = 1'b0;
        mem_ack = 1'b0;
        opcode  = 3'd0;
        #1;
        check({tag, "_outs"}, 32'({mem_req, mem_we, ir_load, alu_en, reg_we, pc_en, halted, fault, state}), 0);
        step;
        n_reset = 1'b1;
        #1;
        check({tag, "_state"}, 32'(state), 0);
    endtask

    task automatic begin_run;
        start = 1'b1;
        step;
        start = 1'b0;
    endtask

    task automatic next_instr(input string tag);
`ifdef SEQ_SINGLE_STEP_EN
        #1;
        check({tag, "_idle"}, 32'(state), 0);
        check({tag, "_idle_pc"}, 32'(pc_en), 0);
        begin_run;
`else
        check({tag, "_fetch_again"}, 32'(state), 1);
`endif
    endtask

    task automatic fetch_decode(input logic [2:0] op, input string tag);
        mem_ack = 1'b1;
        #1;
        check({tag, "_f_state"}, 32'(state), 1);
        check({tag, "_f_irload"}, 32'(ir_load), 1);
        check({tag, "_f_req"}, 32'({mem_req, mem_we}), 2);
        step;
        mem_ack = 1'b0;
        opcode  = op;
        #1;
        check({tag, "_d_state"}, 32'(state), 2);
        check({tag, "_d_strobes"}, 32'({mem_req, ir_load, alu_en, reg_we, pc_en}), 0);
        step;
    endtask

    task automatic mem_instr(input logic [2:0] op, input logic we_exp, input logic rwe_exp, input string tag);
        fetch_decode(op, tag);
        #1;
        check({tag, "_e_state"}, 32'(state), 3);
        check({tag, "_e_strobes"}, 32'({mem_req, reg_we, alu_en}), 0);
        step;
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1'b0;
            #1;
            check({tag, "_wait_state"}, 32'(state), 4);
            check({tag, "_wait_req_we"}, 32'({mem_req, mem_we}), 32'({1'b1, we_exp}));
            check({tag, "_wait_regwe"}, 32'(reg_we), 0);
            step;
        end
        mem_ack = 1'b1;
        #1;
        check({tag, "_ack_req_we"}, 32'({mem_req, mem_we}), 32'({1'b1, we_exp}));
        check({tag, "_ack_regwe"}, 32'(reg_we), 32'(rwe_exp));
        step;
        mem_ack = 1'b0;
        #1;
        check({tag, "_adv_state"}, 32'(state), 5);
        check({tag, "_adv_pc_req"}, 32'({pc_en, mem_req, reg_we}), 4);
        step;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_reset = 1'b0;
        start   = 1'b0;
        mem_ack = 1'b0;
        opcode  = 3'd0;
        step;
        do_reset("init");

        // NOP stream with ack tied high: 1,2,3,5 per instruction, ack in IDLE ignored.
        mem_ack = 1'b1;
        #1;
        check("idle_ack_ignored", 32'({mem_req, ir_load}), 0);
        begin_run;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("nop_fetch", 32'({state, ir_load, pc_en}), 32'({3'd1, 1'b1, 1'b0}));
            step;
            #1;
            check("nop_decode", 32'({state, ir_load, pc_en}), 32'({3'd2, 1'b0, 1'b0}));
            step;
            #1;
            check("nop_exec", 32'({state, ir_load, pc_en}), 32'({3'd3, 1'b0, 1'b0}));
            step;
            #1;
            check("nop_adv", 32'({state, ir_load, pc_en}), 32'({3'd5, 1'b0, 1'b1}));
            step;
            next_instr("nop");
        end
        #1;
        do_reset("nop_rst");

        // ALU with opcode changed after DECODE, then HALT.
        step;
        begin_run;
        fetch_decode(3'd1, "alu");
        opcode = 3'd0;
        #1;
        check("alu_exec_state", 32'(state), 3);
        check("alu_exec_strobes", 32'({alu_en, reg_we, pc_en}), 6);
        step;
        #1;
        check("alu_adv_strobes", 32'({alu_en, reg_we, pc_en}), 1);
        step;
        next_instr("alu");
        fetch_decode(3'd7, "halt");
        #1;
        check("halt_state", 32'({state, halted, fault, pc_en}), 32'({3'd6, 1'b1, 1'b0, 1'b0}));
        start = 1'b1;
        step;
        step;
        start = 1'b0;
        #1;
        check("halt_sticky", 32'({state, halted}), 32'({3'd6, 1'b1}));
        do_reset("halt_rst");

        // LOAD then STORE, each acked on the fourth MEM cycle.
        step;
        begin_run;
        mem_instr(3'd2, 1'b0, 1'b1, "load");
        next_instr("load");
        mem_instr(3'd3, 1'b1, 1'b0, "store");
        next_instr("store");

        // Reset in the middle of a MEM wait drops the request at once.
        fetch_decode(3'd2, "mid");
        step;
        mem_ack = 1'b0;
        #1;
        check("mid_req", 32'(mem_req), 1);
        do_reset("mid_rst");

        // No ack in FETCH: 16 waiting cycles, then FAULT.
        step;
        begin_run;
        mem_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("to_wait", 32'({state, fault, pc_en}), 32'({3'd1, 1'b0, 1'b0}));
            step;
        end
        #1;
        check("to_fault", 32'({state, fault, mem_req, pc_en}), 32'({3'd7, 1'b1, 1'b0, 1'b0}));
        start = 1'b1;
        step;
        step;
        start = 1'b0;
        #1;
        check("to_sticky", 32'({state, fault}), 32'({3'd7, 1'b1}));
        do_reset("to_rst");

        // Ack on the limit cycle wins over the timeout.
        step;
        begin_run;
        for (int i = 0; i < 15; i++) begin
            mem_ack = 1'b0;
            step;
        end
        mem_ack = 1'b1;
        #1;
        check("lim_fetch", 32'({state, ir_load}), 32'({3'd1, 1'b1}));
        step;
        mem_ack = 1'b0;
        opcode  = 3'd0;
        #1;
        check("lim_decode", 32'({state, fault}), 32'({3'd2, 1'b0}));
        step;
        step;
        #1;
        check("lim_adv", 32'({state, pc_en}), 32'({3'd5, 1'b1}));
        step;

        // Illegal opcode 5 faults without a pc_en.
        do_reset("ill_pre");
        step;
        begin_run;
        fetch_decode(3'd5, "ill");
        #1;
        check("ill_fault", 32'({state, fault, pc_en, halted}), 32'({3'd7, 1'b1, 1'b0, 1'b0}));
        start = 1'b1;
        step;
        step;
        start = 1'b0;
        #1;
        check("ill_sticky", 32'(state), 7);
        do_reset("ill_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
